cache_ctrl: RTL

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_pkg.sv | 20 ++
 rtl/cache_line_store.sv | 60 ++++++
 rtl/cache_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache controller slice.
// Holds the default geometry (address, tag and data widths plus the derived
// line count) and the controller state encoding. Imported by cache_ctrl and
// cache_line_store so that every file agrees on the same values.
package cache_ctrl_pkg;

    localparam int ADDR_SIZE_DEF  = 8;
    localparam int TAG_SIZE_DEF   = 3;
    localparam int DATA_SIZE_DEF  = 8;
    localparam int CACHE_SIZE_DEF = 32'd1 << (ADDR_SIZE_DEF - TAG_SIZE_DEF);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/cache_line_store.sv
// Storage for the direct-mapped cache: one valid bit, one tag and one data
// word per line.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   rd_idx                read-port line index (asynchronous read)
//   rd_valid/tag/data     contents of the indexed line
//   wr_en, wr_idx         write-port strobe and line index
//   wr_valid/tag/data     values written into the indexed line
// Only the valid array is cleared by reset; tag and data are don't-care
// while their valid bit is low.
module cache_line_store
    import cache_ctrl_pkg::*;
#(
    parameter int IDX_SIZE  = ADDR_SIZE_DEF - TAG_SIZE_DEF,
    parameter int TAG_SIZE  = TAG_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_SIZE-1:0]  rd_idx,
    output logic                 rd_valid,
    output logic [TAG_SIZE-1:0]  rd_tag,
    output logic [DATA_SIZE-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IDX_SIZE-1:0]  wr_idx,
    input  logic                 wr_valid,
    input  logic [TAG_SIZE-1:0]  wr_tag,
    input  logic [DATA_SIZE-1:0] wr_data
);

    localparam int LINES = 32'd1 << IDX_SIZE;

    logic [LINES-1:0]     valid_r;
    logic [TAG_SIZE-1:0]  tag_r  [LINES];
    logic [DATA_SIZE-1:0] data_r [LINES];

    // Valid bits: cleared as a whole by reset, one bit written per update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_idx] <= wr_valid;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data payload: no reset, only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request, accepted only when idle
//   cpu_rdata, cpu_ready, hit      registered response; cpu_ready is a
//                                  one-cycle pulse, hit/cpu_rdata valid with it
//   mem_req/we/addr/wdata          backing-memory request, held until mem_ack
//   mem_rdata, mem_ack             backing-memory completion and fill data
// All outputs are registered, so cpu_ready appears the cycle after the
// controller passes through RESP.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int TAG_SIZE  = TAG_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [DATA_SIZE-1:0] cpu_wdata,
    output logic [DATA_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 hit,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack
);

    localparam int IDX_SIZE = ADDR_SIZE - TAG_SIZE;

    state_t                state_r;
    state_t                state_next_s;
    logic                  we_r;
    logic [ADDR_SIZE-1:0]  addr_r;
    logic [DATA_SIZE-1:0]  wdata_r;
    logic                  lkp_hit_r;

    logic [IDX_SIZE-1:0]   idx_s;
    logic [TAG_SIZE-1:0]   tag_s;
    logic                  line_valid_s;
    logic [TAG_SIZE-1:0]   line_tag_s;
    logic [DATA_SIZE-1:0]  line_data_s;
    logic                  hit_s;
    logic                  mem_done_s;
    logic                  st_we_s;
    logic [DATA_SIZE-1:0]  st_wdata_s;

    assign idx_s      = addr_r[IDX_SIZE-1:0];
    assign tag_s      = addr_r[ADDR_SIZE-1:IDX_SIZE];
    assign hit_s      = line_valid_s && (line_tag_s == tag_s);
    // An ack only counts while a memory request is actually outstanding.
    assign mem_done_s = mem_ack && mem_req;

    cache_line_store #(
        .IDX_SIZE  (IDX_SIZE),
        .TAG_SIZE  (TAG_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) u_store (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx_s),
        .rd_valid (line_valid_s),
        .rd_tag   (line_tag_s),
        .rd_data  (line_data_s),
        .wr_en    (st_we_s),
        .wr_idx   (idx_s),
        .wr_valid (1'b1),
        .wr_tag   (tag_s),
        .wr_data  (st_wdata_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req) state_next_s = ST_LOOKUP;
                else         state_next_s = ST_IDLE;
            end
            ST_LOOKUP: begin
                if (we_r)       state_next_s = ST_MEM_WR;
                else if (hit_s) state_next_s = ST_RESP;
                else            state_next_s = ST_MEM_RD;
            end
            ST_MEM_RD, ST_MEM_WR: begin
                if (mem_done_s) state_next_s = ST_RESP;
                else            state_next_s = state_r;
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Line update: refill on a read miss, data-only update on a write hit.
    // A write miss never touches the line.
    always_comb begin
        st_we_s    = 1'b0;
        st_wdata_s = wdata_r;
        if (state_r == ST_MEM_RD && mem_done_s) begin
            st_we_s    = 1'b1;
            st_wdata_s = mem_rdata;
        end else if (state_r == ST_MEM_WR && mem_done_s && lkp_hit_r) begin
            st_we_s    = 1'b1;
            st_wdata_s = wdata_r;
        end else begin
            st_we_s    = 1'b0;
            st_wdata_s = wdata_r;
        end
    end

    // Request capture in IDLE and lookup-result capture in LOOKUP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            lkp_hit_r <= 1'b0;
        end else begin
            if (state_r == ST_IDLE && cpu_req) begin
                we_r    <= cpu_we;
                addr_r  <= cpu_addr;
                wdata_r <= cpu_wdata;
            end
            if (state_r == ST_LOOKUP) begin
                lkp_hit_r <= hit_s;
            end
        end
    end

    // Registered outputs; memory-side signals track the state being entered
    // so mem_req rises together with MEM_RD/MEM_WR and drops with the ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_ready <= 1'b0;
            hit       <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cpu_ready <= (state_r == ST_RESP);
            hit       <= (state_r == ST_RESP) ? lkp_hit_r : 1'b0;
            mem_req   <= (state_next_s == ST_MEM_RD) || (state_next_s == ST_MEM_WR);
            mem_we    <= (state_next_s == ST_MEM_WR);
            if (state_r == ST_LOOKUP) begin
                mem_addr  <= addr_r;
                mem_wdata <= we_r ? wdata_r : '0;
            end
            if (state_r == ST_LOOKUP && !we_r && hit_s) begin
                cpu_rdata <= line_data_s;
            end else if (state_r == ST_MEM_RD && mem_done_s) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule
